rom_loader: RTL and testbench

ROM_LOADER -- requirements
Module: rom_loader

---
 rtl/rom_loader.sv | 171 +++++++++++++++++
 tb/tb_rom_loader.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_loader.sv
// rom_loader: on a rising edge of start, reads NUM_UNITS consecutive ROM words
// starting at BASE_ADDR and strobes each into data register `address`, then
// pulses start_network_controller once the whole set has been written.
// Optional feature macro: ROM_LOADER_CHECKSUM_EN -- reads one trailing word at
// BASE_ADDR+NUM_UNITS, compares it with the modulo-2^DATA_W sum of the loaded
// words, and reports a mismatch on checksum_err instead of pulsing the controller.
module rom_loader #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ROM_ADDR_W  = 10,
  parameter int unsigned NUM_UNITS   = 4,
  parameter int unsigned UNIT_ADDR_W = 2,
  parameter int unsigned BASE_ADDR   = 1,
  parameter int unsigned ROM_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic                   rom_en,
  output logic [ROM_ADDR_W-1:0]  rom_addr,
  input  logic [DATA_W-1:0]      rom_data,
  output logic [DATA_W-1:0]      rom_output,
  output logic [UNIT_ADDR_W-1:0] address,
  output logic                   writeData,
  output logic                   start_network_controller,
`ifdef ROM_LOADER_CHECKSUM_EN
  output logic                   checksum_err,
`endif
  output logic                   busy
);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, WRITE, DONE} state_t;

  localparam logic [UNIT_ADDR_W-1:0] LAST_IDX  = UNIT_ADDR_W'(NUM_UNITS - 1);
  localparam logic [1:0]             LAST_WAIT = 2'(ROM_LATENCY - 1);
  localparam logic [ROM_ADDR_W-1:0]  BASE      = ROM_ADDR_W'(BASE_ADDR);

  state_t                 state;
  state_t                 state_next;
  logic                   start_q;
  logic [UNIT_ADDR_W-1:0] idx;
  logic [1:0]             wcnt;
  logic                   start_edge;
  logic                   wait_last;
  logic                   last_unit;

`ifdef ROM_LOADER_CHECKSUM_EN
  // chk_phase marks the extra fetch of the stored checksum word.
  logic                   chk_phase;
  logic [DATA_W-1:0]      sum;
`endif

  assign start_edge = start && !start_q;
  assign wait_last  = (wcnt == LAST_WAIT);
  assign last_unit  = (idx == LAST_IDX);

  // State register; reset returns to IDLE from anywhere, mid-load included.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of statement order.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first so no path leaves state_next unassigned (no latch).
    state_next = state;
    unique case (state)
      IDLE:  if (start_edge) state_next = FETCH;
      FETCH: state_next = WAIT;
      WAIT: begin
        if (wait_last) begin
`ifdef ROM_LOADER_CHECKSUM_EN
          state_next = chk_phase ? DONE : WRITE;
`else
          state_next = WRITE;
`endif
        end
      end
      WRITE: begin
        if (!last_unit) begin
          state_next = FETCH;
        end else begin
`ifdef ROM_LOADER_CHECKSUM_EN
          state_next = FETCH;
`else
          state_next = DONE;
`endif
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Decoded outputs; idx is 0 outside a load so rom_addr rests at BASE_ADDR.
  always_comb begin
    rom_en    = (state == FETCH);
    writeData = (state == WRITE);
    busy      = (state != IDLE);
`ifdef ROM_LOADER_CHECKSUM_EN
    rom_addr  = BASE + (chk_phase ? ROM_ADDR_W'(NUM_UNITS) : ROM_ADDR_W'(idx));
    start_network_controller = (state == DONE) && !checksum_err;
`else
    rom_addr  = BASE + ROM_ADDR_W'(idx);
    start_network_controller = (state == DONE);
`endif
  end

  // Datapath: start edge detect, unit/wait counters and the captured word.
  always_ff @(posedge clk) begin
    if (reset) begin
      start_q    <= 1'b0;
      idx        <= '0;
      wcnt       <= '0;
      rom_output <= '0;
      address    <= '0;
`ifdef ROM_LOADER_CHECKSUM_EN
      chk_phase    <= 1'b0;
      sum          <= '0;
      checksum_err <= 1'b0;
`endif
    end else begin
      start_q <= start;
      unique case (state)
        IDLE: begin
          if (start_edge) begin
            idx <= '0;
`ifdef ROM_LOADER_CHECKSUM_EN
            chk_phase    <= 1'b0;
            sum          <= '0;
            checksum_err <= 1'b0;
`endif
          end
        end
        FETCH: wcnt <= '0;
        WAIT: begin
          wcnt <= wcnt + 2'd1;
          if (wait_last) begin
`ifdef ROM_LOADER_CHECKSUM_EN
            if (chk_phase) begin
              checksum_err <= (rom_data != sum);
            end else begin
              rom_output <= rom_data;
              address    <= idx;
              sum        <= sum + rom_data;
            end
`else
            rom_output <= rom_data;
            address    <= idx;
`endif
          end
        end
        WRITE: begin
          if (!last_unit) idx <= idx + 1'b1;
`ifdef ROM_LOADER_CHECKSUM_EN
          else            chk_phase <= 1'b1;
`endif
        end
        DONE: begin
          idx <= '0;
`ifdef ROM_LOADER_CHECKSUM_EN
          chk_phase <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: scoreboard bench for rom_loader. Three instances: defaults,
// ROM_LATENCY=3/NUM_UNITS=2, and BASE_ADDR=1022 for address wrap.
// Checksum cases are compiled in when ROM_LOADER_CHECKSUM_EN is defined.
module tb_rom_loader;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef ROM_LOADER_CHECKSUM_EN
  localparam int EXTRA1 = 2;  // extra FETCH + 1 WAIT
  localparam int EXTRA2 = 4;  // extra FETCH + 3 WAIT
  localparam int NADDR3 = 5;
`else
  localparam int EXTRA1 = 0;
  localparam int EXTRA2 = 0;
  localparam int NADDR3 = 4;
`endif

  // ---------------- instance 1: defaults ----------------
  logic        start1, rom_en1, wd1, snc1, busy1;
  logic [9:0]  rom_addr1;
  logic [31:0] rom_data1, rom_out1;
  logic [1:0]  addr1;
  logic [31:0] rom1 [1024];
`ifdef ROM_LOADER_CHECKSUM_EN
  logic        ckerr1;
`endif

  rom_loader dut1 (
    .clk(clk), .reset(reset), .start(start1), .rom_en(rom_en1), .rom_addr(rom_addr1),
    .rom_data(rom_data1), .rom_output(rom_out1), .address(addr1), .writeData(wd1),
    .start_network_controller(snc1),
`ifdef ROM_LOADER_CHECKSUM_EN
    .checksum_err(ckerr1),
`endif
    .busy(busy1)
  );

  always @(posedge clk) rom_data1 <= rom_en1 ? rom1[rom_addr1] : 32'h0;

  // ---------------- instance 2: latency 3, two units ----------------
  logic        start2, rom_en2, wd2, snc2, busy2;
  logic [9:0]  rom_addr2;
  logic [31:0] rom_data2, rom_out2;
  logic [1:0]  addr2;
  logic [31:0] rom2 [1024];
  logic [31:0] pipe2 [3];
`ifdef ROM_LOADER_CHECKSUM_EN
  logic        ckerr2;
`endif

  rom_loader #(.ROM_LATENCY(3), .NUM_UNITS(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .rom_en(rom_en2), .rom_addr(rom_addr2),
    .rom_data(rom_data2), .rom_output(rom_out2), .address(addr2), .writeData(wd2),
    .start_network_controller(snc2),
`ifdef ROM_LOADER_CHECKSUM_EN
    .checksum_err(ckerr2),
`endif
    .busy(busy2)
  );

  always @(posedge clk) begin
    pipe2[0] <= rom_en2 ? rom2[rom_addr2] : 32'h0;
    pipe2[1] <= pipe2[0];
    pipe2[2] <= pipe2[1];
  end
  assign rom_data2 = pipe2[2];

  // ---------------- instance 3: base address wrap ----------------
  logic        start3, rom_en3, wd3, snc3, busy3;
  logic [9:0]  rom_addr3;
  logic [31:0] rom_data3, rom_out3;
  logic [1:0]  addr3;
`ifdef ROM_LOADER_CHECKSUM_EN
  logic        ckerr3;
`endif
  assign rom_data3 = 32'h0;

  rom_loader #(.BASE_ADDR(1022)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .rom_en(rom_en3), .rom_addr(rom_addr3),
    .rom_data(rom_data3), .rom_output(rom_out3), .address(addr3), .writeData(wd3),
    .start_network_controller(snc3),
`ifdef ROM_LOADER_CHECKSUM_EN
    .checksum_err(ckerr3),
`endif
    .busy(busy3)
  );

  // ---------------- checking infrastructure ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic        is_done;
    logic [1:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   wr_cyc[$];
  int   done_cyc = 0;
  int   done_cnt = 0;

  task automatic push_exp(input logic is_done, input logic [1:0] a, input logic [31:0] d);
    exp_t e;
    e.is_done = is_done;
    e.addr    = a;
    e.data    = d;
    sb.push_back(e);
  endtask

  // Expected full load of ROM[1..4] = A,B,C,D into registers 0..3.
  task automatic push_load1(input logic expect_done);
    push_exp(1'b0, 2'd0, 32'hA);
    push_exp(1'b0, 2'd1, 32'hB);
    push_exp(1'b0, 2'd2, 32'hC);
    push_exp(1'b0, 2'd3, 32'hD);
    if (expect_done) push_exp(1'b1, 2'd0, 32'h0);
  endtask

  // Monitor for instance 1: every strobe/pulse pops one scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    if (wd1) begin
      wr_cyc.push_back(cyc);
      if (sb.size() == 0) check("unexpected_write", 1, 0);
      else begin
        e = sb.pop_front();
        check("sb_kind_write", e.is_done, 0);
        check("sb_address", addr1, e.addr);
        check("sb_rom_output", rom_out1, e.data);
      end
    end
    if (snc1) begin
      done_cyc = cyc;
      done_cnt++;
      if (sb.size() == 0) check("unexpected_done", 1, 0);
      else begin
        e = sb.pop_front();
        check("sb_kind_done", e.is_done, 1);
      end
    end
  end

  task automatic pulse_start1();
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
  endtask

  // Bounded wait until the scoreboard drains and instance 1 is idle.
  task automatic wait_load1(input string name);
    int n = 0;
    while ((sb.size() != 0 || busy1) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({name, "_complete"}, (n < 300), 1);
  endtask

  initial begin
    int d0;
    int n;
    int f0;
    int dc2;
    int w2c[$];
    logic [31:0] w2d[$];
    logic [1:0]  w2a[$];
    int a3[$];
    int exp3 [4];

    for (int i = 0; i < 1024; i++) begin
      rom1[i] = 32'h0;
      rom2[i] = 32'h0;
    end
    rom1[1] = 32'hA; rom1[2] = 32'hB; rom1[3] = 32'hC; rom1[4] = 32'hD; rom1[5] = 32'h2E;
    rom2[1] = 32'h11; rom2[2] = 32'h22; rom2[3] = 32'h33;
    pipe2[0] = 32'h0; pipe2[1] = 32'h0; pipe2[2] = 32'h0;
    rom_data1 = 32'h0;

    reset = 1'b1; start1 = 1'b0; start2 = 1'b0; start3 = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_rom_en", rom_en1, 0);
    check("rst_rom_addr", rom_addr1, 1);
    check("rst_rom_output", rom_out1, 0);
    check("rst_address", addr1, 0);
    check("rst_writeData", wd1, 0);
    check("rst_snc", snc1, 0);
    check("rst_busy", busy1, 0);
`ifdef ROM_LOADER_CHECKSUM_EN
    check("rst_checksum_err", ckerr1, 0);
`endif
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Basic load: 3-cycle write spacing, pulse one cycle after the last write
    push_load1(1'b1);
    wr_cyc.delete();
    d0 = done_cnt;
    pulse_start1();
    wait_load1("basic");
    check("basic_n_writes", wr_cyc.size(), 4);
    if (wr_cyc.size() == 4) begin
      check("basic_spacing_1", wr_cyc[1] - wr_cyc[0], 3);
      check("basic_spacing_2", wr_cyc[2] - wr_cyc[1], 3);
      check("basic_spacing_3", wr_cyc[3] - wr_cyc[2], 3);
      check("basic_done_after_write", done_cyc - wr_cyc[3], 1 + EXTRA1);
    end
    check("basic_done_count", done_cnt - d0, 1);
    check("idle_hold_rom_output", rom_out1, 32'hD);
    check("idle_hold_address", addr1, 3);
    check("idle_rom_addr", rom_addr1, 1);
`ifdef ROM_LOADER_CHECKSUM_EN
    check("basic_checksum_err", ckerr1, 0);
`endif

    // Start edge while busy is ignored
    push_load1(1'b1);
    d0 = done_cnt;
    pulse_start1();
    repeat (4) @(negedge clk);
    check("busy_mid_load", busy1, 1);
    pulse_start1();
    wait_load1("busy_ignore");
    repeat (15) @(negedge clk);
    check("busy_ignore_done_count", done_cnt - d0, 1);
    check("busy_ignore_drained", sb.size(), 0);

    // Start held across reset release, then held high for 40 cycles
    push_load1(1'b1);
    d0 = done_cnt;
    @(negedge clk);
    reset = 1'b1;
    start1 = 1'b1;
    @(negedge clk);
    check("reset_dominates_start", busy1, 0);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    start1 = 1'b0;
    wait_load1("held");
    repeat (5) @(negedge clk);
    check("held_done_count", done_cnt - d0, 1);

    // Reset asserted during the second WAIT
    push_exp(1'b0, 2'd0, 32'hA);
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    n = 0;
    while (!(rom_en1 && rom_addr1 == 10'd2) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("midrst_reach_second_fetch", (n < 20), 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_rom_en", rom_en1, 0);
    check("midrst_rom_addr", rom_addr1, 1);
    check("midrst_rom_output", rom_out1, 0);
    check("midrst_address", addr1, 0);
    check("midrst_writeData", wd1, 0);
    check("midrst_snc", snc1, 0);
    check("midrst_busy", busy1, 0);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    check("midrst_drained", sb.size(), 0);
    push_load1(1'b1);
    pulse_start1();
    wait_load1("reload");

`ifdef ROM_LOADER_CHECKSUM_EN
    // Checksum mismatch suppresses the pulse and latches checksum_err
    rom1[5] = 32'h2F;
    push_load1(1'b0);
    d0 = done_cnt;
    pulse_start1();
    wait_load1("cks_bad");
    repeat (2) @(negedge clk);
    check("cks_bad_no_pulse", done_cnt - d0, 0);
    check("cks_bad_err", ckerr1, 1);
    repeat (8) @(negedge clk);
    check("cks_bad_sticky", ckerr1, 1);
    rom1[5] = 32'h2E;
    push_load1(1'b1);
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    check("cks_cleared_on_start", ckerr1, 0);
    wait_load1("cks_good");
    check("cks_good_err", ckerr1, 0);
`endif

    // Instance 2: latency 3, two units
    f0 = -1; dc2 = -1;
    start2 = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      start2 = 1'b0;
      if (rom_en2 && f0 < 0) f0 = cyc;
      if (wd2) begin
        w2c.push_back(cyc);
        w2d.push_back(rom_out2);
        w2a.push_back(addr2);
      end
      if (snc2) dc2 = cyc;
    end
    check("lat3_n_writes", w2c.size(), 2);
    if (w2c.size() == 2) begin
      check("lat3_spacing", w2c[1] - w2c[0], 5);
      check("lat3_data0", w2d[0], 32'h11);
      check("lat3_data1", w2d[1], 32'h22);
      check("lat3_addr1", w2a[1], 1);
    end
    check("lat3_saw_done", (dc2 >= 0), 1);
    check("lat3_done_time", dc2 - f0, 10 + EXTRA2);

    // Instance 3: rom_addr wraps modulo 2^ROM_ADDR_W
    exp3[0] = 1022; exp3[1] = 1023; exp3[2] = 0; exp3[3] = 1;
    start3 = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      start3 = 1'b0;
      if (rom_en3) a3.push_back(int'(rom_addr3));
    end
    check("wrap_n_fetches", a3.size(), NADDR3);
    if (a3.size() >= 4) begin
      for (int i = 0; i < 4; i++) check("wrap_rom_addr", a3[i], exp3[i]);
    end

    check("sb_drain_final", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
